irq_ctl: RTL and testbench

- Interrupt and reset sequencer for the microcoded 65C02 core.
- Sits between the memory data bus and the opcode input of the microcode controller.
- At each opcode fetch (sync) it either passes the fetched opcode through or injects BRK (8'h00), and supplies the vector low byte and the B flag value.
- Also owns the reset hold-off, WAI stall and STP halt, so the microcode controller never needs to know why a BRK sequence started.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/irq_ctl_if.sv | 28 ++
 rtl/irq_ctl_int_sync.sv | 30 +++
 rtl/irq_ctl.sv | 126 ++++++++++++
 tb/tb_irq_ctl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and types for the 65C02 interrupt/reset sequencer.
package cpu_pkg;

  localparam logic [7:0] VEC_NMI = 8'hFA;
  localparam logic [7:0] VEC_RST = 8'hFC;
  localparam logic [7:0] VEC_IRQ = 8'hFE;
  localparam logic [7:0] OP_BRK  = 8'h00;

  typedef enum logic [1:0] {
    HOLD,
    RUN,
    WAIT,
    STOP
  } irq_state_t;

endpackage

// File: rtl/irq_ctl_if.sv
// Opcode/interrupt bus between the microcode controller and irq_ctl.
interface irq_ctl_if;

  logic       sync;
  logic [7:0] DB;
  logic [7:0] op;
  logic       I;
  logic       irq_n;
  logic       nmi_n;
  logic       wai;
  logic       stp;
  logic       rdy;
  logic [7:0] vec;
  logic       bflag;
  logic       we_inh;
  logic       take;

  modport master (
    output sync, DB, I, irq_n, nmi_n, wai, stp,
    input  op, rdy, vec, bflag, we_inh, take
  );

  modport slave (
    input  sync, DB, I, irq_n, nmi_n, wai, stp,
    output op, rdy, vec, bflag, we_inh, take
  );

endinterface

// File: rtl/irq_ctl_int_sync.sv
// Pin synchronizer (one or two flops) with a registered falling-edge pulse.
module int_sync #(
  parameter bit TWO_STAGE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic fall
);

  logic s1;
  logic s2;

  // Flops reset high so an idle-high pin never produces a spurious edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      fall <= 1'b0;
    end else begin
      s1   <= d;
      s2   <= s1;
      fall <= TWO_STAGE ? (s2 & ~s1) : (s1 & ~d);
    end
  end

  assign level = TWO_STAGE ? s2 : s1;

endmodule

// File: rtl/irq_ctl.sv
// Interrupt/reset sequencer: injects BRK at opcode fetch and owns reset
// hold-off, WAI stall and STP halt for the microcoded 65C02.
module irq_ctl
  import cpu_pkg::*;
#(
  parameter int RESET_CYCLES = 2,
  parameter int NMI_SYNC     = 1
) (
  input  logic       clk,
  input  logic       reset,
  irq_ctl_if.slave   bus
);

  irq_state_t state;
  logic [3:0] counter;
  logic       nmi_pend;
  logic       rst_pend;
  logic       rdy_q;
  logic [7:0] vec_q;
  logic       bflag_q;
  logic       we_inh_q;

  logic irq_n_s;
  logic nmi_fall;
  logic nmi_level_unused;
  logic irq_fall_unused;
  logic irq_act;
  logic take_c;

  int_sync #(.TWO_STAGE(NMI_SYNC != 0)) u_nmi_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.nmi_n),
    .level (nmi_level_unused),
    .fall  (nmi_fall)
  );

  int_sync #(.TWO_STAGE(NMI_SYNC != 0)) u_irq_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.irq_n),
    .level (irq_n_s),
    .fall  (irq_fall_unused)
  );

  assign irq_act = !irq_n_s && !bus.I;
  assign take_c  = (state == RUN) && bus.sync && (rst_pend || nmi_pend || irq_act);

  assign bus.take   = take_c;
  assign bus.op     = take_c ? OP_BRK : bus.DB;
  assign bus.rdy    = rdy_q;
  assign bus.vec    = vec_q;
  assign bus.bflag  = bflag_q;
  assign bus.we_inh = we_inh_q;

  // A new NMI edge is applied after the take-clear so that set wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= HOLD;
      counter  <= 4'd0;
      nmi_pend <= 1'b0;
      rst_pend <= 1'b0;
      rdy_q    <= 1'b0;
      vec_q    <= VEC_RST;
      bflag_q  <= 1'b0;
      we_inh_q <= 1'b1;
    end else begin
      unique case (state)
        HOLD: begin
          if (counter == 4'(RESET_CYCLES - 1)) begin
            state    <= RUN;
            rdy_q    <= 1'b1;
            rst_pend <= 1'b1;
          end else begin
            counter <= counter + 4'd1;
          end
        end
        RUN: begin
          if (bus.sync) begin
            if (rst_pend) begin
              vec_q    <= VEC_RST;
              bflag_q  <= 1'b0;
              we_inh_q <= 1'b1;
              rst_pend <= 1'b0;
            end else if (nmi_pend) begin
              vec_q    <= VEC_NMI;
              bflag_q  <= 1'b0;
              we_inh_q <= 1'b0;
              nmi_pend <= 1'b0;
            end else if (irq_act) begin
              vec_q    <= VEC_IRQ;
              bflag_q  <= 1'b0;
              we_inh_q <= 1'b0;
            end else begin
              if (bus.DB == OP_BRK) vec_q <= VEC_IRQ;
              bflag_q  <= 1'b1;
              we_inh_q <= 1'b0;
            end
          end
          if (bus.stp) begin
            state    <= STOP;
            rdy_q    <= 1'b0;
            nmi_pend <= 1'b0;
          end else if (bus.wai) begin
            state <= WAIT;
            rdy_q <= 1'b0;
          end
        end
        WAIT: begin
          if (!irq_n_s || nmi_pend) begin
            state <= RUN;
            rdy_q <= 1'b1;
          end
        end
        STOP: begin
          state <= STOP;
        end
        default: state <= HOLD;
      endcase

      if (nmi_fall && ((state == WAIT) || (state == RUN && !bus.stp)))
        nmi_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_irq_ctl.sv
// Directed bench for irq_ctl: vector table plus hand-built multi-cycle sequences.
module tb_irq_ctl;

  typedef struct {
    logic       rst;
    logic       sync;
    logic [7:0] db;
    logic       i_flag;
    logic       irq_n;
    logic       nmi_n;
    logic [7:0] e_op;
    logic       e_take;
    logic       e_rdy;
    logic [7:0] e_vec;
    logic       e_bflag;
    logic       e_we;
  } row_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  irq_ctl_if bus();

  irq_ctl #(
    .RESET_CYCLES (2),
    .NMI_SYNC     (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  row_t tbl [20];

  localparam bit [10:0] NMI_SEQ  = 11'b000_0000_0010;
  localparam bit [10:0] SYNC_SEQ = 11'b101_0101_0000;
  localparam bit [10:0] TAKE_SEQ = 11'b000_0101_0000;
  localparam bit [7:0]  STP_NMI  = 8'b0000_0011;

  function automatic row_t mk(input logic rst, input logic sync, input logic [7:0] db,
                              input logic i_flag, input logic irq_n, input logic nmi_n,
                              input logic [7:0] e_op, input logic e_take, input logic e_rdy,
                              input logic [7:0] e_vec, input logic e_bflag, input logic e_we);
    row_t r;
    r.rst = rst; r.sync = sync; r.db = db; r.i_flag = i_flag; r.irq_n = irq_n; r.nmi_n = nmi_n;
    r.e_op = e_op; r.e_take = e_take; r.e_rdy = e_rdy; r.e_vec = e_vec; r.e_bflag = e_bflag; r.e_we = e_we;
    return r;
  endfunction

  task automatic applyStimulus(input row_t r);
    reset     = r.rst;
    bus.sync  = r.sync;
    bus.DB    = r.db;
    bus.I     = r.i_flag;
    bus.irq_n = r.irq_n;
    bus.nmi_n = r.nmi_n;
    bus.wai   = 1'b0;
    bus.stp   = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;

    //            rst sync DB     I  irq nmi   op     tk rdy vec    b  we
    tbl[0]  = mk(1, 0, 8'hA9, 1, 1, 1, 8'hA9, 0, 0, 8'hFC, 0, 1);
    tbl[1]  = mk(1, 0, 8'hA9, 1, 1, 1, 8'hA9, 0, 0, 8'hFC, 0, 1);
    tbl[2]  = mk(0, 0, 8'hA9, 1, 1, 1, 8'hA9, 0, 0, 8'hFC, 0, 1);
    tbl[3]  = mk(0, 0, 8'hA9, 1, 1, 1, 8'hA9, 0, 0, 8'hFC, 0, 1);
    tbl[4]  = mk(0, 0, 8'hA9, 1, 1, 1, 8'hA9, 0, 1, 8'hFC, 0, 1);
    tbl[5]  = mk(0, 1, 8'hA9, 1, 1, 1, 8'h00, 1, 1, 8'hFC, 0, 1);
    tbl[6]  = mk(0, 0, 8'hA9, 1, 1, 1, 8'hA9, 0, 1, 8'hFC, 0, 1);
    tbl[7]  = mk(0, 1, 8'hEA, 1, 1, 1, 8'hEA, 0, 1, 8'hFC, 0, 1);
    tbl[8]  = mk(0, 0, 8'hEA, 1, 1, 1, 8'hEA, 0, 1, 8'hFC, 1, 0);
    tbl[9]  = mk(0, 0, 8'hEA, 0, 0, 0, 8'hEA, 0, 1, 8'hFC, 1, 0);
    tbl[10] = mk(0, 0, 8'hEA, 0, 0, 0, 8'hEA, 0, 1, 8'hFC, 1, 0);
    tbl[11] = mk(0, 0, 8'hEA, 0, 0, 0, 8'hEA, 0, 1, 8'hFC, 1, 0);
    tbl[12] = mk(0, 1, 8'hEA, 0, 0, 0, 8'h00, 1, 1, 8'hFC, 1, 0);
    tbl[13] = mk(0, 0, 8'hEA, 0, 0, 0, 8'hEA, 0, 1, 8'hFA, 0, 0);
    tbl[14] = mk(0, 1, 8'hEA, 0, 0, 0, 8'h00, 1, 1, 8'hFA, 0, 0);
    tbl[15] = mk(0, 0, 8'hEA, 0, 0, 0, 8'hEA, 0, 1, 8'hFE, 0, 0);
    tbl[16] = mk(0, 1, 8'hEA, 1, 0, 0, 8'hEA, 0, 1, 8'hFE, 0, 0);
    tbl[17] = mk(0, 0, 8'hEA, 1, 0, 0, 8'hEA, 0, 1, 8'hFE, 1, 0);
    tbl[18] = mk(0, 1, 8'h00, 1, 0, 0, 8'h00, 0, 1, 8'hFE, 1, 0);
    tbl[19] = mk(0, 0, 8'hEA, 1, 0, 0, 8'hEA, 0, 1, 8'hFE, 1, 0);

    applyStimulus(tbl[0]);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) begin
      applyStimulus(tbl[i]);
      #2;
      checkOutput($sformatf("row%0d op", i),     bus.op,     tbl[i].e_op);
      checkOutput($sformatf("row%0d take", i),   bus.take,   tbl[i].e_take);
      checkOutput($sformatf("row%0d rdy", i),    bus.rdy,    tbl[i].e_rdy);
      checkOutput($sformatf("row%0d vec", i),    bus.vec,    tbl[i].e_vec);
      checkOutput($sformatf("row%0d bflag", i),  bus.bflag,  tbl[i].e_bflag);
      checkOutput($sformatf("row%0d we_inh", i), bus.we_inh, tbl[i].e_we);
      step();
    end

    // Second NMI edge lands in the cycle the first NMI is taken.
    bus.I = 1'b1; bus.irq_n = 1'b1; bus.nmi_n = 1'b1; bus.sync = 1'b0; bus.DB = 8'hEA;
    repeat (3) step();
    for (int j = 0; j < 11; j++) begin
      bus.nmi_n = NMI_SEQ[j];
      bus.sync  = SYNC_SEQ[j];
      #2;
      checkOutput($sformatf("coll%0d take", j), bus.take, TAKE_SEQ[j]);
      checkOutput($sformatf("coll%0d op", j), bus.op, TAKE_SEQ[j] ? 8'h00 : 8'hEA);
      if (j == 5 || j == 7)
        checkOutput($sformatf("coll%0d vec", j), bus.vec, 8'hFA);
      step();
    end
    bus.sync = 1'b1; bus.DB = 8'h00;
    #2;
    checkOutput("softbrk op", bus.op, 8'h00);
    checkOutput("softbrk take", bus.take, 1'b0);
    step();
    bus.sync = 1'b0; bus.DB = 8'hEA;
    #2;
    checkOutput("softbrk vec", bus.vec, 8'hFE);
    checkOutput("softbrk bflag", bus.bflag, 1'b1);
    step();

    // WAI, then masked IRQ wakes the core without being taken.
    bus.wai = 1'b1;
    #2;
    checkOutput("wai0 rdy", bus.rdy, 1'b1);
    step();
    bus.wai = 1'b0;
    for (int k = 1; k < 8; k++) begin
      if (k == 5) bus.irq_n = 1'b0;
      #2;
      checkOutput($sformatf("wait%0d rdy", k), bus.rdy, 1'b0);
      step();
    end
    bus.sync = 1'b1; bus.DB = 8'hEA;
    #2;
    checkOutput("wake rdy", bus.rdy, 1'b1);
    checkOutput("wake op", bus.op, 8'hEA);
    checkOutput("wake take", bus.take, 1'b0);
    step();
    bus.irq_n = 1'b1; bus.sync = 1'b0;

    // STP together with WAI: halt, NMI edge ignored.
    bus.stp = 1'b1; bus.wai = 1'b1;
    #2;
    step();
    bus.stp = 1'b0; bus.wai = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.nmi_n = STP_NMI[k];
      bus.sync  = 1'b1;
      #2;
      checkOutput($sformatf("stop%0d rdy", k), bus.rdy, 1'b0);
      checkOutput($sformatf("stop%0d take", k), bus.take, 1'b0);
      checkOutput($sformatf("stop%0d op", k), bus.op, 8'hEA);
      step();
    end

    // One-cycle reset out of STOP replays the reset sequence.
    bus.nmi_n = 1'b1; bus.sync = 1'b0;
    reset = 1'b1;
    #2;
    step();
    reset = 1'b0;
    #2;
    checkOutput("rst1 rdy", bus.rdy, 1'b0);
    checkOutput("rst1 vec", bus.vec, 8'hFC);
    checkOutput("rst1 bflag", bus.bflag, 1'b0);
    checkOutput("rst1 we_inh", bus.we_inh, 1'b1);
    checkOutput("rst1 take", bus.take, 1'b0);
    step();
    #2;
    checkOutput("rst2 rdy", bus.rdy, 1'b0);
    step();
    bus.sync = 1'b1;
    #2;
    checkOutput("rst3 rdy", bus.rdy, 1'b1);
    checkOutput("rst3 op", bus.op, 8'h00);
    checkOutput("rst3 take", bus.take, 1'b1);
    step();
    bus.sync = 1'b0;
    #2;
    checkOutput("rst4 vec", bus.vec, 8'hFC);
    checkOutput("rst4 we_inh", bus.we_inh, 1'b1);
    checkOutput("rst4 bflag", bus.bflag, 1'b0);
    step();
    bus.sync = 1'b1;
    #2;
    checkOutput("rst5 op", bus.op, 8'hEA);
    checkOutput("rst5 take", bus.take, 1'b0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
